// File: rtl/cpu64_l1_refill_ctrl.sv
// cpu64_l1_refill_ctrl: L1 miss/refill controller for the 8-way, 64-set, 64 B-line L1.
// Latency: clean miss 11 cycles accept->done; a dirty victim adds 16 cycles plus write stalls.
// Backpressure: one miss at a time (miss_ready_o only in IDLE); mw/mr valids hold until ready.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   miss_valid_i/miss_ready_o,
//   miss_set_i, miss_tag_i            miss request from the L1 pipeline
//   set_o, way_o, valid_i, dirty_i,
//   vtag_i                            meta-array lookup of the current set / victim way
//   plru_valid_o, plru_victim_i,
//   plru_access_o, plru_way_o         PLRU victim query and post-refill update
//   rd_en_o, rd_way_o, rd_beat_o,
//   rd_data_i                         data-array read for writeback (data 1 cycle later)
//   mw_*                              memory write beats (dirty victim writeback)
//   mr_req_*, mr_addr_o               memory read request for the missing line
//   mr_data_valid_i, mr_data_i        memory read beats, in order, no backpressure
//   fill_*                            data-array write of incoming beats
//   tag_we_o, tag_way_o, tag_o        tag write of the new line (valid=1, dirty=0)
//   done_o, done_way_o                one-cycle refill-complete pulse
module cpu64_l1_refill_ctrl #(
  parameter int TAG_W = 52
) (
  input  logic               clk_i,
  input  logic               rst_i,
  // miss request
  input  logic               miss_valid_i,
  output logic               miss_ready_o,
  input  logic [5:0]         miss_set_i,
  input  logic [TAG_W-1:0]   miss_tag_i,
  // meta array
  output logic [5:0]         set_o,
  output logic [2:0]         way_o,
  input  logic [7:0]         valid_i,
  input  logic [7:0]         dirty_i,
  input  logic [TAG_W-1:0]   vtag_i,
  // PLRU
  output logic [7:0]         plru_valid_o,
  input  logic [2:0]         plru_victim_i,
  output logic               plru_access_o,
  output logic [2:0]         plru_way_o,
  // data-array read
  output logic               rd_en_o,
  output logic [2:0]         rd_way_o,
  output logic [2:0]         rd_beat_o,
  input  logic [63:0]        rd_data_i,
  // memory write
  output logic               mw_valid_o,
  input  logic               mw_ready_i,
  output logic [TAG_W+11:0]  mw_addr_o,
  output logic [63:0]        mw_data_o,
  output logic               mw_last_o,
  // memory read request
  output logic               mr_req_valid_o,
  input  logic               mr_req_ready_i,
  output logic [TAG_W+11:0]  mr_addr_o,
  // memory read data
  input  logic               mr_data_valid_i,
  input  logic [63:0]        mr_data_i,
  // data-array fill
  output logic               fill_we_o,
  output logic [2:0]         fill_way_o,
  output logic [2:0]         fill_beat_o,
  output logic [63:0]        fill_data_o,
  // tag write
  output logic               tag_we_o,
  output logic [2:0]         tag_way_o,
  output logic [TAG_W-1:0]   tag_o,
  // completion
  output logic               done_o,
  output logic [2:0]         done_way_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VICTIM,
    S_WB_RD,
    S_WB_SEND,
    S_RD_REQ,
    S_RD_DATA,
    S_COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         beat_q, beat_d;
  logic [5:0]         set_q, set_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic [2:0]         victim_q, victim_d;
  logic [63:0]        mw_data_q, mw_data_d;
  // High during the first WB_SEND cycle of a beat: rd_data_i is live that
  // cycle only, so it is forwarded to mw_data_o and captured for any stall.
  logic               snd_first_q, snd_first_d;

  logic               victim_dirty;

  // Victim needs writeback only if it holds a valid, modified line.
  assign victim_dirty = valid_i[plru_victim_i] & dirty_i[plru_victim_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      beat_q      <= 3'd0;
      set_q       <= 6'd0;
      tag_q       <= '0;
      vtag_q      <= '0;
      victim_q    <= 3'd0;
      mw_data_q   <= 64'd0;
      snd_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      set_q       <= set_d;
      tag_q       <= tag_d;
      vtag_q      <= vtag_d;
      victim_q    <= victim_d;
      mw_data_q   <= mw_data_d;
      snd_first_q <= snd_first_d;
    end
  end

  always_comb begin
    // state defaults
    state_d      = state_q;
    beat_d       = beat_q;
    set_d        = set_q;
    tag_d        = tag_q;
    vtag_d       = vtag_q;
    victim_d     = victim_q;
    mw_data_d    = mw_data_q;
    snd_first_d  = 1'b0;

    // output defaults: strobes low, payloads zero
    miss_ready_o   = 1'b0;
    set_o          = set_q;
    way_o          = victim_q;
    plru_valid_o   = 8'd0;
    plru_access_o  = 1'b0;
    plru_way_o     = 3'd0;
    rd_en_o        = 1'b0;
    rd_way_o       = 3'd0;
    rd_beat_o      = 3'd0;
    mw_valid_o     = 1'b0;
    mw_addr_o      = '0;
    mw_data_o      = 64'd0;
    mw_last_o      = 1'b0;
    mr_req_valid_o = 1'b0;
    mr_addr_o      = '0;
    fill_we_o      = 1'b0;
    fill_way_o     = 3'd0;
    fill_beat_o    = 3'd0;
    fill_data_o    = 64'd0;
    tag_we_o       = 1'b0;
    tag_way_o      = 3'd0;
    tag_o          = '0;
    done_o         = 1'b0;
    done_way_o     = 3'd0;

    case (state_q)
      S_IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          set_d   = miss_set_i;
          tag_d   = miss_tag_i;
          beat_d  = 3'd0;
          state_d = S_VICTIM;
        end
      end

      S_VICTIM: begin
        // The PLRU picks from this set's valid mask; the meta array then
        // returns the victim's tag through way_o in the same cycle.
        plru_valid_o = valid_i;
        way_o        = plru_victim_i;
        victim_d     = plru_victim_i;
        vtag_d       = vtag_i;
        state_d      = victim_dirty ? S_WB_RD : S_RD_REQ;
      end

      S_WB_RD: begin
        rd_en_o     = 1'b1;
        rd_way_o    = victim_q;
        rd_beat_o   = beat_q;
        snd_first_d = 1'b1;
        state_d     = S_WB_SEND;
      end

      S_WB_SEND: begin
        if (snd_first_q) begin
          mw_data_d = rd_data_i;
        end
        mw_valid_o = 1'b1;
        mw_addr_o  = {vtag_q, set_q, 6'b0};
        mw_data_o  = mw_data_d;
        mw_last_o  = (beat_q == 3'd7);
        if (mw_ready_i) begin
          if (beat_q == 3'd7) begin
            beat_d  = 3'd0;
            state_d = S_RD_REQ;
          end else begin
            beat_d  = beat_q + 3'd1;
            state_d = S_WB_RD;
          end
        end
      end

      S_RD_REQ: begin
        mr_req_valid_o = 1'b1;
        mr_addr_o      = {tag_q, set_q, 6'b0};
        if (mr_req_ready_i) begin
          state_d = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        // Beats are written straight through; memory cannot be stalled.
        if (mr_data_valid_i) begin
          fill_we_o   = 1'b1;
          fill_way_o  = victim_q;
          fill_beat_o = beat_q;
          fill_data_o = mr_data_i;
          if (beat_q == 3'd7) begin
            beat_d  = 3'd0;
            state_d = S_COMMIT;
          end else begin
            beat_d  = beat_q + 3'd1;
          end
        end
      end

      S_COMMIT: begin
        tag_we_o      = 1'b1;
        tag_way_o     = victim_q;
        tag_o         = tag_q;
        plru_access_o = 1'b1;
        plru_way_o    = victim_q;
        done_o        = 1'b1;
        done_way_o    = victim_q;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu64_l1_refill_ctrl.sv
// tb_cpu64_l1_refill_ctrl: randomized + directed bench for the L1 refill controller.
// A transaction-level model predicts writeback beats, read address, fill beats,
// commit contents and miss latency; every cycle is compared against it.
module tb_cpu64_l1_refill_ctrl;
  localparam int TAG_W = 52;
  localparam int AW    = TAG_W + 12;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               miss_valid_i;
  logic               miss_ready_o;
  logic [5:0]         miss_set_i;
  logic [TAG_W-1:0]   miss_tag_i;
  logic [5:0]         set_o;
  logic [2:0]         way_o;
  logic [7:0]         valid_i;
  logic [7:0]         dirty_i;
  logic [TAG_W-1:0]   vtag_i;
  logic [7:0]         plru_valid_o;
  logic [2:0]         plru_victim_i;
  logic               plru_access_o;
  logic [2:0]         plru_way_o;
  logic               rd_en_o;
  logic [2:0]         rd_way_o;
  logic [2:0]         rd_beat_o;
  logic [63:0]        rd_data_i;
  logic               mw_valid_o;
  logic               mw_ready_i;
  logic [AW-1:0]      mw_addr_o;
  logic [63:0]        mw_data_o;
  logic               mw_last_o;
  logic               mr_req_valid_o;
  logic               mr_req_ready_i;
  logic [AW-1:0]      mr_addr_o;
  logic               mr_data_valid_i;
  logic [63:0]        mr_data_i;
  logic               fill_we_o;
  logic [2:0]         fill_way_o;
  logic [2:0]         fill_beat_o;
  logic [63:0]        fill_data_o;
  logic               tag_we_o;
  logic [2:0]         tag_way_o;
  logic [TAG_W-1:0]   tag_o;
  logic               done_o;
  logic [2:0]         done_way_o;

  always #5 clk_i = ~clk_i;

  cpu64_l1_refill_ctrl #(.TAG_W(TAG_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
    .miss_set_i(miss_set_i), .miss_tag_i(miss_tag_i),
    .set_o(set_o), .way_o(way_o), .valid_i(valid_i), .dirty_i(dirty_i), .vtag_i(vtag_i),
    .plru_valid_o(plru_valid_o), .plru_victim_i(plru_victim_i),
    .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
    .rd_en_o(rd_en_o), .rd_way_o(rd_way_o), .rd_beat_o(rd_beat_o), .rd_data_i(rd_data_i),
    .mw_valid_o(mw_valid_o), .mw_ready_i(mw_ready_i), .mw_addr_o(mw_addr_o),
    .mw_data_o(mw_data_o), .mw_last_o(mw_last_o),
    .mr_req_valid_o(mr_req_valid_o), .mr_req_ready_i(mr_req_ready_i), .mr_addr_o(mr_addr_o),
    .mr_data_valid_i(mr_data_valid_i), .mr_data_i(mr_data_i),
    .fill_we_o(fill_we_o), .fill_way_o(fill_way_o), .fill_beat_o(fill_beat_o),
    .fill_data_o(fill_data_o),
    .tag_we_o(tag_we_o), .tag_way_o(tag_way_o), .tag_o(tag_o),
    .done_o(done_o), .done_way_o(done_way_o)
  );

  // Meta array contents as seen by the controller.
  logic [7:0]       valid_r [64];
  logic [7:0]       dirty_r [64];
  logic [TAG_W-1:0] vtag_r  [512];
  assign valid_i = valid_r[set_o];
  assign dirty_i = dirty_r[set_o];
  assign vtag_i  = vtag_r[{set_o, way_o}];

  // Data array contents (way*8+beat) and memory read data for the current miss.
  logic [63:0] mem [64];
  logic [63:0] fill_dat [8];

  int vecs = 0;
  int errs = 0;

  // Stimulus configuration
  bit cfg_rand, cfg_gap, stray_en;
  int stall_beat, stall_len, stall_cnt;

  // Model state
  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
  } mwb_t;
  mwb_t        exp_mw[$];
  int          cyc = 0;
  bit          busy, mr_pend, data_phase, commit_due;
  int          fbeat, stalls, acc_cyc, done_cyc, last_lat;
  int          n_acc = 0, n_done = 0, n_mw = 0;
  logic [5:0]  m_set;
  logic [TAG_W-1:0] m_tag;
  logic [2:0]  m_vic;
  logic [7:0]  m_val;
  bit          m_dirty;
  logic [63:0] first_mw_addr;
  bit          first_mw_seen;
  bit          mw_hold, mr_hold, rd_pend;
  logic [63:0] mw_sv_addr, mw_sv_data, mr_sv_addr;
  logic        mw_sv_last;
  int          rd_idx;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Called once per cycle at the falling edge.
  function automatic void check_cycle();
    bit   cn;
    bit   exp_we;
    mwb_t b;
    logic [TAG_W-1:0] vt;

    chk("miss_ready", miss_ready_o, !busy);

    // commit: exactly one cycle after the eighth fill beat
    cn = commit_due;
    commit_due = 0;
    chk("done", done_o, cn);
    chk("tag_we", tag_we_o, cn);
    chk("plru_access", plru_access_o, cn);
    if (cn) begin
      chk("done_way", done_way_o, m_vic);
      chk("tag_way", tag_way_o, m_vic);
      chk("plru_way", plru_way_o, m_vic);
      chk("tag", tag_o, m_tag);
      chk("latency", cyc - acc_cyc, 11 + (m_dirty ? 16 : 0) + stalls);
      last_lat = cyc - acc_cyc;
      done_cyc = cyc;
      busy = 0;
      n_done++;
    end

    // fill beats mirror memory read beats during the data phase
    exp_we = data_phase && mr_data_valid_i;
    chk("fill_we", fill_we_o, exp_we);
    if (exp_we) begin
      if (fill_we_o) begin
        chk("fill_way", fill_way_o, m_vic);
        chk("fill_beat", fill_beat_o, fbeat);
        chk("fill_data", fill_data_o, fill_dat[fbeat]);
      end
      fbeat++;
      if (fbeat == 8) begin
        data_phase = 0;
        commit_due = 1;
      end
    end else if (data_phase) begin
      stalls++;
    end

    // memory read request
    if (mr_hold) begin
      chk("mr_hold_valid", mr_req_valid_o, 1);
      chk("mr_hold_addr", mr_addr_o, mr_sv_addr);
    end
    if (!(mr_pend && exp_mw.size() == 0)) begin
      chk("mr_req_idle", mr_req_valid_o, 0);
    end else if (mr_req_valid_o && mr_req_ready_i) begin
      chk("mr_addr", mr_addr_o, {m_tag, m_set, 6'b0});
      mr_pend = 0;
      data_phase = 1;
      fbeat = 0;
    end
    if (mr_req_valid_o && !mr_req_ready_i) stalls++;
    mr_hold = mr_req_valid_o && !mr_req_ready_i;
    mr_sv_addr = mr_addr_o;

    // data-array reads for writeback
    if (exp_mw.size() == 0) begin
      chk("rd_en_idle", rd_en_o, 0);
    end else if (rd_en_o) begin
      chk("rd_way", rd_way_o, m_vic);
      chk("rd_beat", rd_beat_o, 8 - exp_mw.size());
    end
    rd_pend = rd_en_o;
    rd_idx  = int'(rd_way_o) * 8 + int'(rd_beat_o);

    // memory write beats
    if (mw_hold) begin
      chk("mw_hold_valid", mw_valid_o, 1);
      chk("mw_hold_addr", mw_addr_o, mw_sv_addr);
      chk("mw_hold_data", mw_data_o, mw_sv_data);
      chk("mw_hold_last", mw_last_o, mw_sv_last);
    end
    if (exp_mw.size() == 0) begin
      chk("mw_idle", mw_valid_o, 0);
    end else if (mw_valid_o && mw_ready_i) begin
      b = exp_mw.pop_front();
      chk("mw_addr", mw_addr_o, b.addr);
      chk("mw_data", mw_data_o, b.data);
      chk("mw_last", mw_last_o, b.last);
      if (!first_mw_seen) first_mw_addr = mw_addr_o;
      first_mw_seen = 1;
      n_mw++;
    end
    if (mw_valid_o && !mw_ready_i) stalls++;
    mw_hold    = mw_valid_o && !mw_ready_i;
    mw_sv_addr = mw_addr_o;
    mw_sv_data = mw_data_o;
    mw_sv_last = mw_last_o;

    // victim lookup cycle
    if (busy && cyc == acc_cyc + 1) begin
      chk("plru_valid", plru_valid_o, m_val);
      chk("set_o", set_o, m_set);
      chk("way_o", way_o, m_vic);
    end else begin
      chk("plru_valid_idle", plru_valid_o, 0);
    end

    // new miss accepted this cycle
    if (!rst_i && miss_valid_i && miss_ready_o) begin
      m_set   = miss_set_i;
      m_tag   = miss_tag_i;
      m_vic   = plru_victim_i;
      m_val   = valid_r[m_set];
      m_dirty = valid_r[m_set][m_vic] & dirty_r[m_set][m_vic];
      vt      = vtag_r[{m_set, m_vic}];
      exp_mw.delete();
      if (m_dirty) begin
        for (int i = 0; i < 8; i++) begin
          b.addr = {vt, m_set, 6'b0};
          b.data = mem[int'(m_vic) * 8 + i];
          b.last = (i == 7);
          exp_mw.push_back(b);
        end
      end
      busy = 1;
      mr_pend = 1;
      acc_cyc = cyc;
      stalls = 0;
      first_mw_seen = 0;
      n_acc++;
    end

    if (rst_i) begin
      busy = 0;
      mr_pend = 0;
      data_phase = 0;
      commit_due = 0;
      fbeat = 0;
      mw_hold = 0;
      mr_hold = 0;
      exp_mw.delete();
    end
  endfunction

  // Responder inputs, applied just after each rising edge.
  task automatic drive_inputs();
    rd_data_i = rd_pend ? mem[rd_idx] : {$urandom, $urandom};
    if (mw_valid_o && (8 - int'(exp_mw.size())) == stall_beat && stall_cnt < stall_len) begin
      mw_ready_i = 1'b0;
      stall_cnt++;
    end else begin
      mw_ready_i = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    mr_req_ready_i = cfg_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (data_phase && fbeat < 8) begin
      mr_data_valid_i = (cfg_gap || cfg_rand) ? ($urandom_range(0, 2) != 0) : 1'b1;
      mr_data_i = fill_dat[fbeat];
    end else begin
      mr_data_valid_i = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mr_data_i = {$urandom, $urandom};
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    check_cycle();
    @(posedge clk_i);
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic start_miss(input logic [5:0] s, input logic [TAG_W-1:0] t, input logic [2:0] v,
                            input logic [7:0] val, input logic [7:0] dty,
                            input logic [TAG_W-1:0] vt);
    int n0;
    valid_r[s] = val;
    dirty_r[s] = dty;
    vtag_r[{s, v}] = vt;
    plru_victim_i = v;
    for (int i = 0; i < 8; i++) fill_dat[i] = {$urandom, $urandom};
    stall_cnt = 0;
    miss_set_i = s;
    miss_tag_i = t;
    miss_valid_i = 1'b1;
    n0 = n_acc;
    for (int i = 0; i < 50 && n_acc == n0; i++) tick();
    miss_valid_i = 1'b0;
    if (n_acc == n0) chk("accept_timeout", n_acc, n0 + 1);
  endtask

  task automatic wait_done();
    int n0;
    n0 = n_done;
    for (int i = 0; i < 400 && n_done == n0; i++) tick();
    if (n_done == n0) chk("done_timeout", n_done, n0 + 1);
  endtask

  task automatic do_miss(input logic [5:0] s, input logic [TAG_W-1:0] t, input logic [2:0] v,
                         input logic [7:0] val, input logic [7:0] dty,
                         input logic [TAG_W-1:0] vt);
    start_miss(s, t, v, val, dty, vt);
    wait_done();
  endtask

  initial begin
    logic [63:0] r64;
    logic [63:0] r64b;
    int          nm0, nd0, d0;

    rst_i = 1'b1;
    miss_valid_i = 1'b0;
    miss_set_i = '0;
    miss_tag_i = '0;
    plru_victim_i = 3'd0;
    rd_data_i = '0;
    mw_ready_i = 1'b1;
    mr_req_ready_i = 1'b1;
    mr_data_valid_i = 1'b0;
    mr_data_i = '0;
    cfg_rand = 0; cfg_gap = 0; stray_en = 0;
    stall_beat = -1; stall_len = 0; stall_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      valid_r[i] = 8'h00;
      dirty_r[i] = 8'h00;
      mem[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < 512; i++) vtag_r[i] = '0;

    repeat (3) tick();
    chk("rst_miss_ready", miss_ready_o, 1);
    chk("rst_mw_valid", mw_valid_o, 0);
    chk("rst_mr_valid", mr_req_valid_o, 0);
    chk("rst_mr_addr", mr_addr_o, 0);
    chk("rst_mw_addr", mw_addr_o, 0);
    chk("rst_set", set_o, 0);
    chk("rst_done", done_o, 0);
    rst_i = 1'b0;
    tick();

    // Cold set: victim 0, no writeback, done at T+11
    nm0 = n_mw;
    do_miss(6'd5, 52'hA_BCDE_F012_3456, 3'd0, 8'h00, 8'h00, 52'h0);
    chk("cold_latency", last_lat, 11);
    chk("cold_no_mw", n_mw, nm0);
    tick();

    // Full clean set, victim way 6
    do_miss(6'd17, 52'h1_1111_2222_3333, 3'd6, 8'hFF, 8'h00, 52'h77);
    chk("clean_latency", last_lat, 11);
    chk("clean_way", done_way_o === 3'd0 ? 6 : 0, 6);
    tick();

    // Dirty victim way 3, vtag 0x123, set 9
    nm0 = n_mw;
    do_miss(6'd9, 52'h4_5678_9ABC_DEF0, 3'd3, 8'hFF, 8'h08, 52'h123);
    chk("dirty_mw_addr", first_mw_addr, 64'h0000_0000_0012_3240);
    chk("dirty_mw_beats", n_mw - nm0, 8);
    chk("dirty_latency", last_lat, 27);
    tick();

    // Dirty victim with mw_ready low for 3 cycles on beat 2
    stall_beat = 2; stall_len = 3;
    do_miss(6'd20, 52'h0_0000_0000_0BEE, 3'd1, 8'h02, 8'h02, 52'h456);
    chk("stall_latency", last_lat, 30);
    stall_beat = -1; stall_len = 0;
    tick();

    // Reset during WB_SEND of beat 4; late beats afterwards must be ignored
    nd0 = n_done;
    start_miss(6'd33, 52'h9_8765_4321_0FED, 3'd5, 8'h20, 8'h20, 52'h999);
    begin
      int i;
      for (i = 0; i < 100 && !(mw_valid_o && exp_mw.size() == 4); i++) tick();
      if (i == 100) chk("wb4_timeout", exp_mw.size(), 4);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    stray_en = 1;
    chk("postrst_ready", miss_ready_o, 1);
    chk("postrst_mw_valid", mw_valid_o, 0);
    repeat (6) tick();
    stray_en = 0;
    chk("postrst_no_done", n_done, nd0);
    do_miss(6'd33, 52'h2_2222_3333_4444, 3'd5, 8'h20, 8'h20, 52'h999);
    chk("postrst_latency", last_lat, 27);

    // Back-to-back misses with gapped memory data
    cfg_gap = 1;
    do_miss(6'd40, 52'h5_5555_6666_7777, 3'd2, 8'hFF, 8'h00, 52'h1);
    d0 = done_cyc;
    start_miss(6'd41, 52'h8_8888_9999_AAAA, 3'd4, 8'hFF, 8'h10, 52'h2);
    chk("b2b_accept", acc_cyc, d0 + 1);
    wait_done();
    cfg_gap = 0;

    // Randomized misses with random stalls and data gaps
    cfg_rand = 1;
    for (int k = 0; k < 25; k++) begin
      r64  = {$urandom, $urandom};
      r64b = {$urandom, $urandom};
      do_miss(6'($urandom_range(0, 63)), r64[TAG_W-1:0], 3'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom), r64b[TAG_W-1:0]);
      repeat ($urandom_range(0, 2)) tick();
    end
    cfg_rand = 0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
